// File: rtl/fifo_types_pkg.sv
// Shared word/beat types for the narrow FIFO and the word packer behind it.
// Latency: n/a (types only).
// Backpressure: n/a.
package fifo_types;

    localparam int WIDTH_P    = 8;
    localparam int PACK_DEF_P = 4;

    typedef logic [WIDTH_P-1:0]            word_t;
    typedef logic [PACK_DEF_P*WIDTH_P-1:0] packed_t;
    typedef logic [$clog2(PACK_DEF_P+1)-1:0] pcount_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/fifo_synch_1r1w.sv
// Synchronous 1R1W FIFO: valid-ready write side, valid-yumi read side.
// Latency: a written word is visible at the head one cycle later.
// Backpressure: ready_o drops when full; yumi_i must only be raised with v_o.
module fifo_synch_1r1w
    import fifo_types::*;
#(
    parameter int ELS_P = 8
) (
    input  logic  clk_i,
    input  logic  reset_n_i,
    input  word_t data_i,
    input  logic  v_i,
    output logic  ready_o,
    output logic  v_o,
    output word_t data_o,
    input  logic  yumi_i
);

    localparam int AW = (ELS_P > 1) ? $clog2(ELS_P) : 1;
    localparam int CW = $clog2(ELS_P + 1);

    word_t           mem_q [ELS_P];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;

    assign ready_o = (cnt_q != CW'(ELS_P));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = (wr_ptr_q == AW'(ELS_P-1)) ? '0 : wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == AW'(ELS_P-1)) ? '0 : rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: it is only read while cnt_q says it holds data.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK_P FIFO words into one wide beat; flush_i closes a partial beat.
// Latency: beat valid the cycle after its last word (or flush); 1 word/cycle sustained.
// Backpressure: while a beat waits on ready_i, yumi_o stays low so the FIFO fills.
module fifo_word_packer
    import fifo_types::*;
#(
    parameter int PACK_P = PACK_DEF_P
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          valid_i,
    input  word_t                         data_i,
    output logic                          yumi_o,
    input  logic                          flush_i,
    output logic                          valid_o,
    output logic [PACK_P*WIDTH_P-1:0]     data_o,
    output logic [$clog2(PACK_P+1)-1:0]   count_o,
    input  logic                          ready_i
);

    localparam int CW = $clog2(PACK_P + 1);

    pack_state_e                     state_q, state_d;
    logic [PACK_P-1:0][WIDTH_P-1:0]  lane_q, lane_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            take;

    assign valid_o = (state_q == HOLD);
    assign data_o  = lane_q;
    assign count_o = valid_o ? cnt_q : '0;
    // Gated by reset so the FIFO never sees a consume while we are held in reset.
    assign yumi_o  = take & reset_n_i;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        unique case (state_q)
            FILL: begin
                take = valid_i;
                if (valid_i) begin
                    for (int k = 0; k < PACK_P; k++) begin
                        if (cnt_q == CW'(k)) lane_d[k] = data_i;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                if ((cnt_d == CW'(PACK_P)) || (flush_i && (cnt_d != '0))) state_d = HOLD;
            end
            HOLD: begin
                // The accept cycle doubles as the first word of the next beat.
                if (ready_i) begin
                    take      = valid_i;
                    lane_d    = '0;
                    lane_d[0] = valid_i ? data_i : '0;
                    cnt_d     = valid_i ? CW'(1) : '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= FILL;
            lane_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench: 8-deep FIFO feeding the packer, checked against a queue-based packing model.
module tb_fifo_word_packer;
    import fifo_types::*;

    localparam int PACK = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_v_i;
    word_t       f_d_i;
    logic        f_rdy;
    logic        f_v_o;
    word_t       f_d_o;
    logic        yumi;
    logic        flush;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  count_o;
    logic        ready;

    always #5 clk = ~clk;

    fifo_synch_1r1w #(.ELS_P(8)) u_fifo (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(f_d_i), .v_i(f_v_i), .ready_o(f_rdy),
        .v_o(f_v_o), .data_o(f_d_o), .yumi_i(yumi)
    );

    fifo_word_packer #(.PACK_P(PACK)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(f_v_o), .data_i(f_d_o), .yumi_o(yumi),
        .flush_i(flush), .valid_o(valid_o), .data_o(data_o), .count_o(count_o), .ready_i(ready)
    );

    typedef struct {
        logic [31:0] d;
        int          n;
    } beat_t;

    word_t ref_fifo[$];
    word_t partial[$];
    bit    hold;
    beat_t sb[$];
    word_t stim[$];

    int vectors = 0;
    int miscompares = 0;
    int beats_seen = 0;
    int cyc = 0;
    int yumi_n = 0, yumi_first = 0, yumi_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word list grows until it holds PACK words or a flush closes it;
    // a closed beat stays pending until the consumer takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            bit    exp_y;
            word_t w;
            cyc++;
            exp_y = hold ? (ready && f_v_o) : f_v_o;
            check("valid_o", valid_o, hold);
            check("yumi_o", yumi, exp_y);
            if (yumi) begin
                if (yumi_n == 0) yumi_first = cyc;
                yumi_last = cyc;
                yumi_n++;
            end
            w = '0;
            if (exp_y) begin
                if (ref_fifo.size() == 0) check("ref_fifo_underflow", 1, 0);
                else begin
                    w = ref_fifo.pop_front();
                    check("fifo_head", f_d_o, w);
                end
            end
            if (f_v_i && f_rdy) ref_fifo.push_back(f_d_i);
            if (hold) begin
                if (ready) begin
                    hold = 1'b0;
                    partial.delete();
                    if (exp_y) partial.push_back(w);
                end
            end else begin
                if (exp_y) partial.push_back(w);
                if (partial.size() == PACK || (flush && partial.size() > 0)) begin
                    beat_t b;
                    b.d = '0;
                    for (int k = 0; k < partial.size(); k++) b.d[k*8 +: 8] = partial[k];
                    b.n = partial.size();
                    sb.push_back(b);
                    partial.delete();
                    hold = 1'b1;
                end
            end
        end
    end

    // Monitor: any presented beat must match the oldest expected one, every cycle until taken.
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_unexpected: got %h want none", data_o);
            end else begin
                check("beat_data", data_o, sb[0].d);
                check("beat_count", {29'd0, count_o}, sb[0].n);
                if (ready) begin
                    void'(sb.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic push_list();
        int i = 0;
        int guard = 0;
        while (i < stim.size() && guard < 300) begin
            bit acc;
            f_v_i = 1'b1;
            f_d_i = stim[i];
            @(negedge clk);
            acc = f_rdy;
            tick();
            if (acc) i++;
            guard++;
        end
        if (i < stim.size()) check("push_timeout", i, stim.size());
        f_v_i = 1'b0;
        stim.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_count_o", {29'd0, count_o}, 0);
        check("rst_data_o", data_o, 0);
        check("rst_yumi_o", yumi, 0);
        ref_fifo.delete();
        partial.delete();
        sb.delete();
        hold  = 1'b0;
        f_v_i = 1'b0;
        flush = 1'b0;
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int b0;
        rst_n = 1'b0;
        f_v_i = 1'b0;
        f_d_i = '0;
        flush = 1'b0;
        ready = 1'b0;
        hold  = 1'b0;
        #12;
        check("reset_valid_o", valid_o, 0);
        check("reset_yumi_o", yumi, 0);
        check("reset_count_o", {29'd0, count_o}, 0);
        check("reset_data_o", data_o, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(3);

        // Full beat with the consumer always ready.
        ready = 1'b1;
        b0 = beats_seen;
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_list();
        idle(8);
        check("full_beat_n", beats_seen - b0, 1);

        // Partial beat closed by flush, then a flush on an empty packer.
        b0 = beats_seen;
        stim = '{8'hA1, 8'hA2};
        push_list();
        idle(4);
        pulse_flush();
        idle(4);
        pulse_flush();
        idle(4);
        check("flush_beat_n", beats_seen - b0, 1);

        // Backpressure: packer holds beat 1 while the FIFO fills to capacity.
        ready = 1'b0;
        b0 = beats_seen;
        for (int k = 1; k <= 12; k++) stim.push_back(word_t'(k));
        push_list();
        idle(3);
        check("bp_fifo_ready", f_rdy, 0);
        check("bp_yumi", yumi, 0);
        check("bp_valid", valid_o, 1);
        check("bp_held_data", data_o, 32'h04030201);
        ready = 1'b1;
        idle(20);
        check("bp_beats_n", beats_seen - b0, 3);

        // Continuous stream of 16 words.
        b0 = beats_seen;
        yumi_n = 0;
        for (int k = 0; k < 16; k++) stim.push_back(word_t'(8'h80 + k));
        push_list();
        idle(8);
        check("stream_beats_n", beats_seen - b0, 4);
        check("stream_yumi_n", yumi_n, 16);
        check("stream_yumi_span", yumi_last - yumi_first, 15);

        // Reset with a partial beat, then with a held beat.
        stim = '{8'h51, 8'h52, 8'h53};
        push_list();
        idle(4);
        do_reset();
        ready = 1'b0;
        stim = '{8'h61, 8'h62, 8'h63, 8'h64};
        push_list();
        idle(4);
        check("held_before_reset", valid_o, 1);
        do_reset();
        ready = 1'b1;
        b0 = beats_seen;
        stim = '{8'h71, 8'h72, 8'h73, 8'h74};
        push_list();
        idle(6);
        check("post_reset_beats_n", beats_seen - b0, 1);

        // Randomized traffic, backpressure and flushes.
        for (int c = 0; c < 1500; c++) begin
            f_v_i = ($urandom_range(0, 3) != 0);
            f_d_i = word_t'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        f_v_i = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        idle(12);
        pulse_flush();
        idle(6);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_ref_fifo_empty", ref_fifo.size(), 0);
        check("drain_valid_low", valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
